monster_spawn_gen: RTL and testbench



---
 rtl/monster_pkg.sv | 23 ++
 rtl/monster_spawn_gen_lfsr.sv | 46 ++++
 rtl/monster_spawn_gen.sv | 139 +++++++++++++
 tb/tb_monster_spawn_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/monster_pkg.sv
// Shared definitions for the Nexys Starship monster spawn logic: lane indices,
// spawn FSM state encodings and the spawn LFSR polynomial helper.
package monster_pkg;

   localparam logic [1:0] LANE_TOP    = 2'd0;
   localparam logic [1:0] LANE_BOTTOM = 2'd1;
   localparam logic [1:0] LANE_LEFT   = 2'd2;
   localparam logic [1:0] LANE_RIGHT  = 2'd3;

   localparam logic [15:0] LFSR_MASK = 16'hB400;

   typedef enum logic [2:0] {
      SPAWN_IDLE = 3'b001,
      SPAWN_RUN  = 3'b010,
      SPAWN_HALT = 3'b100
   } spawn_state_e;

   // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      lfsr_step = (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
   endfunction

endpackage

// File: rtl/monster_spawn_gen_lfsr.sv
// spawn_lfsr: 16-bit spawn LFSR with load, step enable and an all-zero
// lock-up guard that reloads SEED.
module spawn_lfsr
   import monster_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        step_i,
   input  logic        load_i,
   input  logic [15:0] load_val_i,
   output logic [1:0]  lane_o,
   output logic [7:0]  roll_o
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   // Next LFSR value: load beats the zero guard, which beats stepping.
   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = load_val_i;
      end else if (lfsr_q == 16'h0000) begin
         lfsr_d = SEED;
      end else if (step_i) begin
         lfsr_d = lfsr_step(lfsr_q);
      end else begin
         lfsr_d = lfsr_q;
      end
   end

   // LFSR register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lane_o = lfsr_q[1:0];
   assign roll_o = lfsr_q[15:8];

endmodule

// File: rtl/monster_spawn_gen.sv
// monster_spawn_gen: paced, LFSR-driven spawn requests for the four monster lanes.
// Optional macro SPAWN_SEED_CAPTURE_EN mixes a free-running counter into the per-game seed.
module monster_spawn_gen
   import monster_pkg::*;
#(
   parameter int unsigned TICK_DIV       = 1000000,
   parameter logic [15:0] SEED           = 16'hACE1,
   parameter logic [7:0]  THRESH         = 8'd64,
   parameter int unsigned COOLDOWN_TICKS = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       play_flag,
   input  logic       game_over,
   input  logic [3:0] occupied,
   output logic [3:0] spawn_req,
   output logic       active
);

   localparam logic [19:0] TICK_LAST = 20'(TICK_DIV - 1);
   localparam logic [2:0]  CD_LOAD   = 3'(COOLDOWN_TICKS);

   spawn_state_e    state_q, state_d;
   logic [19:0]     presc_q, presc_d;
   logic [3:0][2:0] cd_q, cd_d;
   logic [3:0]      req_q, req_d;
   logic            active_q, active_d;
   logic            stay_run_s, tick_s, grant_s, load_s;
   logic [1:0]      lane_s;
   logic [7:0]      roll_s;
   logic [15:0]     seed_s;

`ifdef SPAWN_SEED_CAPTURE_EN
   logic [15:0] free_q;

   // Free-running counter sampled as entropy when a game starts.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         free_q <= 16'h0000;
      end else begin
         free_q <= free_q + 16'd1;
      end
   end

   assign seed_s = ((free_q ^ SEED) == 16'h0000) ? SEED : (free_q ^ SEED);
`else
   assign seed_s = SEED;
`endif

   // Game-level state transitions; game_over dominates everywhere.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SPAWN_IDLE: begin
            if (game_over)      state_d = SPAWN_HALT;
            else if (play_flag) state_d = SPAWN_RUN;
            else                state_d = SPAWN_IDLE;
         end
         SPAWN_RUN: begin
            if (game_over)       state_d = SPAWN_HALT;
            else if (!play_flag) state_d = SPAWN_IDLE;
            else                 state_d = SPAWN_RUN;
         end
         SPAWN_HALT: begin
            if (game_over) state_d = SPAWN_HALT;
            else           state_d = SPAWN_IDLE;
         end
         default: state_d = SPAWN_IDLE;
      endcase
   end

   // Datapath only advances when staying in RUN, so a game_over tick never grants.
   assign stay_run_s = (state_q == SPAWN_RUN) && (state_d == SPAWN_RUN);
   assign tick_s     = stay_run_s && (presc_q == TICK_LAST);
   assign load_s     = (state_q == SPAWN_IDLE) && (state_d == SPAWN_RUN);
   assign grant_s    = tick_s && (roll_s < THRESH) && !occupied[lane_s]
                       && !req_q[lane_s] && (cd_q[lane_s] == 3'd0);
   assign active_d   = (state_d == SPAWN_RUN);

   spawn_lfsr #(.SEED(SEED)) u_lfsr (
      .Clk        (Clk),
      .Reset      (Reset),
      .step_i     (tick_s),
      .load_i     (load_s),
      .load_val_i (seed_s),
      .lane_o     (lane_s),
      .roll_o     (roll_s)
   );

   // Prescaler, per-lane request handshake and cooldown counters.
   always_comb begin
      presc_d = 20'd0;
      req_d   = 4'b0000;
      cd_d    = {4{3'd0}};
      if (stay_run_s) begin
         presc_d = tick_s ? 20'd0 : (presc_q + 20'd1);
         for (int i = 0; i < 4; i++) begin
            if (req_q[i] && occupied[i]) begin
               req_d[i] = 1'b0;
               cd_d[i]  = CD_LOAD;
            end else if (grant_s && (lane_s == 2'(i))) begin
               req_d[i] = 1'b1;
               cd_d[i]  = cd_q[i];
            end else if (tick_s && !occupied[i] && (cd_q[i] != 3'd0)) begin
               req_d[i] = req_q[i];
               cd_d[i]  = cd_q[i] - 3'd1;
            end else begin
               req_d[i] = req_q[i];
               cd_d[i]  = cd_q[i];
            end
         end
      end else begin
         presc_d = 20'd0;
         req_d   = 4'b0000;
         cd_d    = {4{3'd0}};
      end
   end

   // State and datapath registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= SPAWN_IDLE;
         presc_q  <= 20'd0;
         cd_q     <= {4{3'd0}};
         req_q    <= 4'b0000;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         cd_q     <= cd_d;
         req_q    <= req_d;
         active_q <= active_d;
      end
   end

   assign spawn_req = req_q;
   assign active    = active_q;

endmodule

// File: tb/tb_monster_spawn_gen.sv
// Directed bench for monster_spawn_gen (TICK_DIV=4, SEED=16'hACE1), with a
// second THRESH=0 instance sharing the same stimulus.
module tb_monster_spawn_gen;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       play_flag = 1'b0;
   logic       game_over = 1'b0;
   logic [3:0] occupied = 4'b0000;
   logic [3:0] spawn_req, zero_req;
   logic       active, zero_active;
   int         errors = 0;
   int         checks = 0;
   logic [3:0] trace1 [40];
   logic [3:0] trace2 [40];

   always #5 Clk = ~Clk;

   monster_spawn_gen #(.TICK_DIV(4), .SEED(16'hACE1), .THRESH(8'd255), .COOLDOWN_TICKS(4)) dut (
      .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .game_over(game_over),
      .occupied(occupied), .spawn_req(spawn_req), .active(active));

   monster_spawn_gen #(.TICK_DIV(4), .SEED(16'hACE1), .THRESH(8'd0), .COOLDOWN_TICKS(4)) dut_zero (
      .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .game_over(game_over),
      .occupied(occupied), .spawn_req(zero_req), .active(zero_active));

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic test_reset();
      step(2);
      checks++;
      if (spawn_req !== 4'b0000) begin errors++; $display("FAIL reset_req: got %b want %b", spawn_req, 4'b0000); end
      checks++;
      if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want %b", active, 1'b0); end
      Reset = 1'b0;
   endtask

   task automatic test_first_grant();
      play_flag = 1'b1;
      step(1);
      checks++;
      if (active !== 1'b1) begin errors++; $display("FAIL run_active: got %b want %b", active, 1'b1); end
      step(3);
      checks++;
      if (spawn_req !== 4'b0000) begin errors++; $display("FAIL pre_tick_req: got %b want %b", spawn_req, 4'b0000); end
      step(1);
      checks++;
      if (spawn_req !== 4'b0010) begin errors++; $display("FAIL first_grant: got %b want %b", spawn_req, 4'b0010); end
   endtask

   // Lane 1 granted at tick 1; ticks 2..11 use lanes 0,0,0,2,3,3,1,0,2,1.
   task automatic test_handshake_cooldown();
      occupied = 4'b0010;
      step(1);
      checks++;
      if (spawn_req !== 4'b0000) begin errors++; $display("FAIL release: got %b want %b", spawn_req, 4'b0000); end
      step(3);
      checks++;
      if (spawn_req !== 4'b0001) begin errors++; $display("FAIL tick2_lane0: got %b want %b", spawn_req, 4'b0001); end
      step(16);
      checks++;
      if (spawn_req !== 4'b1101) begin errors++; $display("FAIL tick6_lanes: got %b want %b", spawn_req, 4'b1101); end
      step(1);
      occupied = 4'b0000;
      step(7);
      checks++;
      if (spawn_req !== 4'b1101) begin errors++; $display("FAIL cooldown_block: got %b want %b", spawn_req, 4'b1101); end
      step(12);
      checks++;
      if (spawn_req !== 4'b1111) begin errors++; $display("FAIL cooldown_expire: got %b want %b", spawn_req, 4'b1111); end
   endtask

   task automatic test_game_over();
      game_over = 1'b1;
      step(1);
      checks++;
      if (spawn_req !== 4'b0000) begin errors++; $display("FAIL go_req: got %b want %b", spawn_req, 4'b0000); end
      checks++;
      if (active !== 1'b0) begin errors++; $display("FAIL go_active: got %b want %b", active, 1'b0); end
      game_over = 1'b0;
      play_flag = 1'b0;
      step(4);
      checks++;
      if (active !== 1'b0) begin errors++; $display("FAIL go_stays_idle: got %b want %b", active, 1'b0); end
      play_flag = 1'b1;
      step(1);
      checks++;
      if (active !== 1'b1) begin errors++; $display("FAIL go_restart: got %b want %b", active, 1'b1); end
   endtask

   task automatic test_go_on_tick();
      step(3);
      game_over = 1'b1;
      step(1);
      checks++;
      if (spawn_req !== 4'b0000) begin errors++; $display("FAIL go_tick_req: got %b want %b", spawn_req, 4'b0000); end
      checks++;
      if (active !== 1'b0) begin errors++; $display("FAIL go_tick_active: got %b want %b", active, 1'b0); end
      game_over = 1'b0;
      play_flag = 1'b0;
      step(2);
   endtask

   task automatic test_thresh_zero();
      logic zero_bad;
      zero_bad = 1'b0;
      play_flag = 1'b1;
      step(1);
      for (int k = 0; k < 4000; k++) begin
         step(1);
         if (zero_req !== 4'b0000) zero_bad = 1'b1;
      end
      checks++;
      if (zero_bad !== 1'b0) begin errors++; $display("FAIL thresh_zero: saw request=%b want %b", zero_bad, 1'b0); end
      checks++;
      if (zero_active !== 1'b1) begin errors++; $display("FAIL thresh_zero_active: got %b want %b", zero_active, 1'b1); end
      checks++;
      if (spawn_req !== 4'b1111) begin errors++; $display("FAIL long_run_req: got %b want %b", spawn_req, 4'b1111); end
   endtask

   task automatic test_play_drop();
      play_flag = 1'b0;
      step(1);
      checks++;
      if (spawn_req !== 4'b0000) begin errors++; $display("FAIL play_drop_req: got %b want %b", spawn_req, 4'b0000); end
      checks++;
      if (active !== 1'b0) begin errors++; $display("FAIL play_drop_active: got %b want %b", active, 1'b0); end
   endtask

   task automatic test_all_occupied();
      logic occ_bad;
      occ_bad = 1'b0;
      occupied = 4'b1111;
      play_flag = 1'b1;
      for (int k = 0; k < 84; k++) begin
         step(1);
         if (spawn_req !== 4'b0000) occ_bad = 1'b1;
      end
      checks++;
      if (occ_bad !== 1'b0) begin errors++; $display("FAIL all_occupied: saw request=%b want %b", occ_bad, 1'b0); end
      play_flag = 1'b0;
      occupied = 4'b0000;
      step(1);
   endtask

   task automatic test_reset_replay();
      int diff;
      diff = 0;
      play_flag = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step(1);
         trace1[k] = spawn_req;
      end
      checks++;
      if (trace1[4] !== 4'b0010) begin errors++; $display("FAIL replay_first: got %b want %b", trace1[4], 4'b0010); end
      checks++;
      if (trace1[24] !== 4'b1111) begin errors++; $display("FAIL replay_tick6: got %b want %b", trace1[24], 4'b1111); end
      #2 Reset = 1'b1;
      #1;
      checks++;
      if (spawn_req !== 4'b0000) begin errors++; $display("FAIL async_reset_req: got %b want %b", spawn_req, 4'b0000); end
      checks++;
      if (active !== 1'b0) begin errors++; $display("FAIL async_reset_active: got %b want %b", active, 1'b0); end
      step(1);
      Reset = 1'b0;
      for (int k = 0; k < 40; k++) begin
         step(1);
         trace2[k] = spawn_req;
         if (trace2[k] !== trace1[k]) diff++;
      end
      checks++;
      if (diff !== 0) begin errors++; $display("FAIL replay_trace: differing cycles=%0d want %0d", diff, 0); end
   endtask

   initial begin
      test_reset();
      test_first_grant();
      test_handshake_cooldown();
      test_game_over();
      test_go_on_tick();
      test_thresh_zero();
      test_play_drop();
      test_all_occupied();
      test_reset_replay();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
